// File: rtl/sa_sched_pkg.sv
// sa_sched_pkg: shared types and constants for the 8x8 systolic tile scheduler
package sa_sched_pkg;
  localparam int SA_N = 8;
  localparam int SA_W = 8;
  localparam int DRAIN_CYC = 2 * SA_N;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, HOLD} state_t;
  function automatic int lane_lo(input int n, input int w, input int i);
    return (n - 1 - i) * w;
  endfunction
endpackage

// File: rtl/sa_skew.sv
// sa_skew: per-lane wavefront skew, lane i delayed i cycles, lanes without a valid bit forced to zero
module sa_skew
  import sa_sched_pkg::*;
#(
  parameter int N = SA_N,
  parameter int WIDTH = SA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic [N*WIDTH-1:0] din,
  output logic [N*WIDTH-1:0] dout
);
  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam int LO = lane_lo(N, WIDTH, i);
    if (i == 0) begin : g_pass
      assign dout[LO+:WIDTH] = vld ? din[LO+:WIDTH] : '0;
    end else begin : g_dly
      logic [WIDTH:0] sr_q [i];
      logic [WIDTH:0] sr_d [i];
      always_comb begin
        sr_d[0] = {vld, din[LO+:WIDTH]};
        for (int j = 1; j < i; j++) sr_d[j] = sr_q[j-1];
      end
      always_ff @(posedge clk) begin
        if (rst) sr_q <= '{default: '0};
        else sr_q <= sr_d;
      end
      assign dout[LO+:WIDTH] = sr_q[i-1][WIDTH] ? sr_q[i-1][WIDTH-1:0] : '0;
    end
  end
endmodule

// File: rtl/sa8_tile_sched.sv
// sa8_tile_sched: clears, feeds with skew, drains and holds one output tile of the 8x8 systolic array
module sa8_tile_sched
  import sa_sched_pkg::*;
#(
  parameter int N = SA_N,
  parameter int WIDTH = SA_W,
  parameter int ADDR_W = 10,
  parameter int K_W = 10
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [K_W-1:0]     k_len,
  input  logic [ADDR_W-1:0]  act_base,
  input  logic [ADDR_W-1:0]  wt_base,
  output logic               busy,
  output logic               done,
  output logic               res_valid,
  input  logic               res_ack,
  output logic               buf_rd_en,
  output logic [ADDR_W-1:0]  act_rd_addr,
  output logic [ADDR_W-1:0]  wt_rd_addr,
  input  logic [N*WIDTH-1:0] act_rd_data,
  input  logic [N*WIDTH-1:0] wt_rd_data,
  output logic [N*WIDTH-1:0] sa_activation,
  output logic [N*WIDTH-1:0] sa_weight,
  output logic               sa_control
);
  state_t state_q, state_d;
  logic [K_W-1:0] k_len_q, k_len_d, k_q, k_d;
  logic [ADDR_W-1:0] act_base_q, act_base_d, wt_base_q, wt_base_d;
  logic [ADDR_W-1:0] act_addr_q, act_addr_d, wt_addr_q, wt_addr_d;
  logic [4:0] drain_q, drain_d;
  logic busy_q, busy_d, done_q, done_d, rv_q, rv_d, rd_en_q, rd_en_d, ctl_q, ctl_d, vld_q;
  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    act_base_d = act_base_q;
    wt_base_d = wt_base_q;
    k_d = k_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CLEAR;
        k_len_d = k_len;
        act_base_d = act_base;
        wt_base_d = wt_base;
      end
      CLEAR: begin
        state_d = (k_len_q == '0) ? HOLD : FEED;
        k_d = '0;
      end
      FEED: begin
        state_d = (k_q == k_len_q - K_W'(1)) ? DRAIN : FEED;
        k_d = k_q + K_W'(1);
        drain_d = '0;
      end
      DRAIN: begin
        state_d = (drain_q == 5'(DRAIN_CYC - 1)) ? HOLD : DRAIN;
        drain_d = drain_q + 5'd1;
      end
      HOLD: state_d = res_ack ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    done_d = state_d == HOLD && state_q != HOLD;
    rv_d = state_d == HOLD;
    rd_en_d = state_d == FEED;
    ctl_d = state_d != CLEAR;
    act_addr_d = rd_en_d ? act_base_q + ADDR_W'(k_d) : '0;
    wt_addr_d = rd_en_d ? wt_base_q + ADDR_W'(k_d) : '0;
  end
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= IDLE;
      k_len_q <= '0;
      act_base_q <= '0;
      wt_base_q <= '0;
      k_q <= '0;
      drain_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rv_q <= 1'b0;
      rd_en_q <= 1'b0;
      ctl_q <= 1'b1;
      act_addr_q <= '0;
      wt_addr_q <= '0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      act_base_q <= act_base_d;
      wt_base_q <= wt_base_d;
      k_q <= k_d;
      drain_q <= drain_d;
      busy_q <= busy_d;
      done_q <= done_d;
      rv_q <= rv_d;
      rd_en_q <= rd_en_d;
      ctl_q <= ctl_d;
      act_addr_q <= act_addr_d;
      wt_addr_q <= wt_addr_d;
      vld_q <= rd_en_q;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign res_valid = rv_q;
  assign buf_rd_en = rd_en_q;
  assign act_rd_addr = act_addr_q;
  assign wt_rd_addr = wt_addr_q;
  assign sa_control = ctl_q;
  sa_skew #(.N(N), .WIDTH(WIDTH)) u_act_skew (
    .clk(clk), .rst(rstn), .vld(vld_q), .din(act_rd_data), .dout(sa_activation)
  );
  sa_skew #(.N(N), .WIDTH(WIDTH)) u_wt_skew (
    .clk(clk), .rst(rstn), .vld(vld_q), .din(wt_rd_data), .dout(sa_weight)
  );
endmodule

// File: tb/tb_sa8_tile_sched.sv
// tb_sa8_tile_sched: scoreboard bench comparing the tile scheduler against a cycle-timeline reference model
module tb_sa8_tile_sched;
  logic clk = 0, rstn = 1, start = 0, res_ack = 0;
  logic [9:0] k_len = 0, act_base = 0, wt_base = 0;
  logic busy, done, res_valid, buf_rd_en, sa_control;
  logic [9:0] act_rd_addr, wt_rd_addr;
  logic [63:0] act_rd_data, wt_rd_data, sa_activation, sa_weight;
  typedef struct {int k; int ab; int wb; int t0;} tile_t;
  tile_t tile_q[$];
  tile_t cur;
  bit act = 0;
  int rd_q[$];
  logic [63:0] act_mem [1024];
  logic [63:0] wt_mem [1024];
  int cyc = 0, total = 0, bad = 0;
  sa8_tile_sched dut (
    .clk(clk), .rstn(rstn), .start(start), .k_len(k_len), .act_base(act_base), .wt_base(wt_base),
    .busy(busy), .done(done), .res_valid(res_valid), .res_ack(res_ack), .buf_rd_en(buf_rd_en),
    .act_rd_addr(act_rd_addr), .wt_rd_addr(wt_rd_addr), .act_rd_data(act_rd_data),
    .wt_rd_data(wt_rd_data), .sa_activation(sa_activation), .sa_weight(sa_weight),
    .sa_control(sa_control)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    act_rd_data <= (buf_rd_en === 1'b1) ? act_mem[act_rd_addr] : {$urandom, $urandom};
    wt_rd_data <= (buf_rd_en === 1'b1) ? wt_mem[wt_rd_addr] : {$urandom, $urandom};
  end
  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask
  task automatic chk1(string nm, logic got, logic exp);
    chk(nm, 64'(got), 64'(exp));
  endtask
  function automatic logic [63:0] exp_bus(bit w, int c);
    logic [63:0] v = '0;
    logic [63:0] m;
    for (int i = 0; i < 8; i++) begin
      int r = c - 3 - i;
      if (act && r >= 0 && r < cur.k) begin
        m = w ? wt_mem[(cur.wb + r) % 1024] : act_mem[(cur.ab + r) % 1024];
        v[(7-i)*8+:8] = m[(7-i)*8+:8];
      end
    end
    return v;
  endfunction
  always @(negedge clk) begin : mon
    int c, hs;
    bit rv;
    if (!act && tile_q.size() > 0 && cyc > tile_q[0].t0) begin
      cur = tile_q.pop_front();
      act = 1;
      for (int r = 0; r < cur.k; r++)
        rd_q.push_back(((cur.ab + r) % 1024) * 1024 + (cur.wb + r) % 1024);
    end
    c = cyc - cur.t0;
    hs = (cur.k == 0) ? 2 : cur.k + 18;
    rv = act && c >= hs;
    chk1("busy", busy, act);
    chk1("sa_control", sa_control, !(act && c == 1));
    chk1("buf_rd_en", buf_rd_en, act && c >= 2 && c <= cur.k + 1);
    chk1("done", done, act && c == hs);
    chk1("res_valid", res_valid, rv);
    chk("sa_activation", sa_activation, exp_bus(0, c));
    chk("sa_weight", sa_weight, exp_bus(1, c));
    if (buf_rd_en === 1'b1) begin
      if (rd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected cycle=%0d got=read exp=no_read", cyc);
      end else chk("rd_addr", 64'({act_rd_addr, wt_rd_addr}), 64'(rd_q.pop_front()));
    end
    if (rv && res_ack) act = 0;
    if (rstn) begin
      act = 0;
      rd_q.delete();
    end
  end
  task automatic wait_hold(int k);
    int n = 0;
    while (res_valid !== 1'b1 && n < k + 40) begin
      @(posedge clk) #1;
      n++;
    end
    chk1("hold_reached", res_valid, 1'b1);
  endtask
  task automatic run_tile(int k, int ab, int wb, int hold);
    @(posedge clk) #1;
    start = 1;
    k_len = 10'(k);
    act_base = 10'(ab);
    wt_base = 10'(wb);
    tile_q.push_back('{k, ab, wb, cyc});
    @(posedge clk) #1;
    start = 0;
    k_len = 10'($urandom);
    act_base = 10'($urandom);
    wt_base = 10'($urandom);
    wait_hold(k);
    repeat (hold) @(posedge clk) #1;
    res_ack = 1;
    @(posedge clk) #1;
    res_ack = 0;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) begin
      act_mem[i] = {$urandom, $urandom};
      wt_mem[i] = {$urandom, $urandom};
    end
    repeat (3) @(posedge clk);
    #1 rstn = 0;
    run_tile(3, 'h010, 'h200, 4);
    act_mem['h020] = 64'h0102030405060708;
    wt_mem['h120] = 64'h0102030405060708;
    run_tile(1, 'h020, 'h120, 0);
    run_tile(0, 5, 6, 0);
    @(posedge clk) #1;
    start = 1;
    k_len = 10'd4;
    act_base = 10'h3FE;
    wt_base = 10'h3FD;
    tile_q.push_back('{4, 'h3FE, 'h3FD, cyc});
    @(posedge clk) #1;
    k_len = 10'($urandom);
    act_base = 10'($urandom);
    wt_base = 10'($urandom);
    wait_hold(4);
    res_ack = 1;
    k_len = 10'd2;
    act_base = 10'd5;
    wt_base = 10'd7;
    tile_q.push_back('{2, 5, 7, cyc + 1});
    @(posedge clk) #1;
    res_ack = 0;
    @(posedge clk) #1;
    start = 0;
    wait_hold(2);
    res_ack = 1;
    @(posedge clk) #1;
    res_ack = 0;
    run_tile(5, 'h100, 'h300, 50);
    @(posedge clk) #1;
    start = 1;
    k_len = 10'd8;
    act_base = 10'h050;
    wt_base = 10'h060;
    tile_q.push_back('{8, 'h050, 'h060, cyc});
    @(posedge clk) #1;
    start = 0;
    @(posedge clk) #1;
    @(posedge clk) #1;
    rstn = 1;
    @(posedge clk) #1;
    rstn = 0;
    run_tile(8, 'h050, 'h060, 1);
    repeat (8) run_tile($urandom_range(0, 24), $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 4));
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
